// File: rtl/iic_sfifo_fwft_gen_pkg.sv
// Shared definitions for the IIC master TX/RX FIFOs.
//   - default data width and depth for the TX and RX data paths
//   - iic_clog2(): ceil(log2(value)), used to size occupancy counters
package iic_sfifo_fwft_gen_pkg;

  localparam int IIC_TX_DW    = 8;
  localparam int IIC_TX_DEPTH = 8;
  localparam int IIC_RX_DW    = 8;
  localparam int IIC_RX_DEPTH = 8;

  // Returns the smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int iic_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iic_sfifo_fwft_gen.sv
// Shift-register first-word-fall-through FIFO for the IIC master data paths.
// mem[0] is always the head word and drives rd_data directly, so a word
// written into an empty FIFO is visible one clock later.
//
// Ports
//   clk_sys   system clock
//   rst       asynchronous reset, active-high
//   flush     synchronous clear of contents and level (flags kept)
//   wr_en     push wr_data
//   wr_data   write data [DW]
//   rd_en     pop the head word
//   rd_data   head word, valid while empty=0, zero while empty=1 [DW]
//   wr_ready  registered: post-update level < RDY_TH
//   empty     level == 0
//   full      level == DEPTH
//   level     current occupancy [AW]
//   eflag     last word is being popped (level == 1 and rd_en)
//   ovf       sticky: write attempted while full without a read
//   udf       sticky: read attempted while empty
//   flag_clr  clears ovf/udf, wins over a same-cycle set
module iic_sfifo_fwft_gen
  import iic_sfifo_fwft_gen_pkg::*;
#(
  parameter  int DW     = IIC_TX_DW,
  parameter  int DEPTH  = IIC_TX_DEPTH,
  parameter  int RDY_TH = 5,
  parameter  int U_DLY  = 1,
  localparam int AW     = iic_clog2(DEPTH + 1)
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          wr_ready,
  output logic          empty,
  output logic          full,
  output logic [AW-1:0] level,
  output logic          eflag,
  output logic          ovf,
  output logic          udf,
  input  logic          flag_clr
);

  localparam logic [AW-1:0] LVL_ONE  = AW'(1);
  localparam logic [AW-1:0] LVL_FULL = AW'(DEPTH);
  localparam logic [AW-1:0] LVL_TH   = AW'(RDY_TH);

  if (DEPTH < 2 || DEPTH > 64 || RDY_TH < 1 || RDY_TH > DEPTH || U_DLY < 0) begin : g_bad_param
    $error("iic_sfifo_fwft_gen: illegal parameter combination");
  end

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] mem_nxt [DEPTH];
  logic [AW-1:0] level_q;
  logic [AW-1:0] level_nxt;
  logic [AW-1:0] level_m1;
  logic          wr_ready_q;
  logic          ovf_q;
  logic          udf_q;
  logic          wr_acc;
  logic          rd_acc;
  logic          ovf_set;
  logic          udf_set;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_FULL);
  assign level_m1 = level_q - LVL_ONE;

  // A full FIFO still accepts a write when a read frees the head slot in
  // the same cycle; full implies non-empty, so that read is always taken.
  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;

  assign ovf_set = wr_en & full & ~rd_en & ~flush;
  assign udf_set = rd_en & empty & ~flush;

  always_comb begin
    level_nxt = level_q;
    if (flush) begin
      level_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      level_nxt = level_q + LVL_ONE;
    end else if (rd_acc && !wr_acc) begin
      level_nxt = level_m1;
    end
  end

  // Per-cell next value. On a pop every cell takes its upper neighbour
  // (the top cell takes zero) so vacated slots are always cleared; a
  // simultaneous push lands in the slot just below the old tail.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    localparam logic [AW-1:0] IDX = AW'(i);
    logic [DW-1:0] above;

    if (i == DEPTH - 1) begin : g_top
      assign above = '0;
    end else begin : g_mid
      assign above = mem[i+1];
    end

    assign mem_nxt[i] = flush                            ? '0      :
                        (rd_acc && wr_acc && IDX == level_m1) ? wr_data :
                        rd_acc                           ? above   :
                        (wr_acc && IDX == level_q)       ? wr_data :
                                                           mem[i];
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      level_q    <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
      level_q    <= level_nxt;
      wr_ready_q <= (level_nxt < LVL_TH);
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (flag_clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (udf_set) udf_q <= 1'b1;
    end
  end

  assign rd_data  = mem[0];
  assign level    = level_q;
  assign wr_ready = wr_ready_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;
  assign eflag    = (level_q == LVL_ONE) & rd_en;

endmodule

// File: tb/tb_iic_sfifo_fwft_gen.sv
module tb_iic_sfifo_fwft_gen;

  logic       clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // DUT A: default build (DW=8, DEPTH=8, RDY_TH=5)
  logic       rst, flush, wr_en, rd_en, flag_clr;
  logic [7:0] wr_data, rd_data;
  logic       wr_ready, empty, full, eflag, ovf, udf;
  logic [3:0] level;

  // DUT B: DEPTH=4, RDY_TH=4 build
  logic       rst_b, flush_b, wr_en_b, rd_en_b, flag_clr_b;
  logic [7:0] wr_data_b, rd_data_b;
  logic       wr_ready_b, empty_b, full_b, eflag_b, ovf_b, udf_b;
  logic [2:0] level_b;

  iic_sfifo_fwft_gen #(.DW(8), .DEPTH(8), .RDY_TH(5), .U_DLY(1)) u_dut (
    .clk_sys(clk_sys), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .wr_ready(wr_ready), .empty(empty), .full(full),
    .level(level), .eflag(eflag), .ovf(ovf), .udf(udf), .flag_clr(flag_clr)
  );

  iic_sfifo_fwft_gen #(.DW(8), .DEPTH(4), .RDY_TH(4), .U_DLY(1)) u_dut_b (
    .clk_sys(clk_sys), .rst(rst_b), .flush(flush_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .rd_en(rd_en_b), .rd_data(rd_data_b), .wr_ready(wr_ready_b), .empty(empty_b), .full(full_b),
    .level(level_b), .eflag(eflag_b), .ovf(ovf_b), .udf(udf_b), .flag_clr(flag_clr_b)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle();
    flush = 0; wr_en = 0; rd_en = 0; flag_clr = 0; wr_data = 8'h00;
  endtask

  // Monitor: every accepted pop on DUT A is checked against the scoreboard.
  always @(negedge clk_sys) begin
    if (!rst && rd_en && !empty && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no pop at %0t", rd_data, $time);
      end else begin
        chk("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; rst_b = 1;
    idle();
    flush_b = 0; wr_en_b = 0; rd_en_b = 0; flag_clr_b = 0; wr_data_b = 8'h00;
    repeat (2) tick();

    // reset state
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);

    rst = 0; rst_b = 0;
    chk("wr_ready_before_edge", wr_ready, 0);
    tick();
    chk("wr_ready_first_edge", wr_ready, 1);
    chk("empty_after_rst", empty, 1);

    // fill with 0x11..0x88
    for (int k = 1; k <= 8; k++) begin
      wr_en = 1; wr_data = 8'(k * 17);
      tick();
      chk("fill_level", level, k);
      chk("fill_head", rd_data, 8'h11);
      chk("fill_wr_ready", wr_ready, (k < 5) ? 1 : 0);
    end
    idle();
    chk("fill_full", full, 1);

    // overflow while full
    wr_en = 1; wr_data = 8'h99;
    tick();
    idle();
    chk("ovf_set", ovf, 1);
    chk("ovf_level", level, 8);
    chk("ovf_head", rd_data, 8'h11);
    flag_clr = 1;
    tick();
    idle();
    chk("ovf_cleared", ovf, 0);

    // pop five words, leaving 0x66 0x77 0x88
    for (int k = 1; k <= 5; k++) exp_q.push_back(8'(k * 17));
    rd_en = 1;
    repeat (5) tick();
    idle();
    chk("pop5_level", level, 3);
    chk("pop5_wr_ready", wr_ready, 1);
    chk("pop5_head", rd_data, 8'h66);

    // simultaneous push/pop at level 3
    exp_q.push_back(8'h66); exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    wr_en = 1; rd_en = 1; wr_data = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rw_level", level, 3);
    end
    idle();
    chk("rw_head", rd_data, 8'hA5);

    // drain the three 0xA5 words
    repeat (3) exp_q.push_back(8'hA5);
    rd_en = 1;
    tick(); tick();
    chk("drain_eflag", eflag, 1);
    tick();
    idle();
    chk("drain_empty", empty, 1);
    chk("drain_rd_data", rd_data, 0);
    chk("drain_level", level, 0);
    chk("drain_eflag_off", eflag, 0);

    // read while empty with a write in the same cycle
    chk("udf_clear", udf, 0);
    rd_en = 1; wr_en = 1; wr_data = 8'h3C;
    tick();
    idle();
    chk("udf_set", udf, 1);
    chk("udf_level", level, 1);
    chk("udf_head", rd_data, 8'h3C);
    exp_q.push_back(8'h3C);
    rd_en = 1;
    #1;
    chk("last_eflag", eflag, 1);
    tick();
    idle();
    chk("last_empty", empty, 1);
    chk("last_rd_data", rd_data, 0);
    chk("udf_sticky", udf, 1);

    // flag_clr beats a same-cycle underflow
    rd_en = 1; flag_clr = 1;
    tick();
    idle();
    chk("clr_priority", udf, 0);
    rd_en = 1;
    tick();
    idle();
    chk("udf_reset_again", udf, 1);

    // flush at level 6
    for (int k = 1; k <= 6; k++) begin
      wr_en = 1; wr_data = 8'(k);
      tick();
    end
    idle();
    chk("pre_flush_level", level, 6);
    chk("pre_flush_wr_ready", wr_ready, 0);
    flush = 1; wr_en = 1; wr_data = 8'hEE;
    tick();
    idle();
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_wr_ready", wr_ready, 1);
    chk("flush_rd_data", rd_data, 0);
    chk("flush_ovf_kept", ovf, 0);
    chk("flush_udf_kept", udf, 1);

    // FIFO still works after flush
    wr_en = 1; wr_data = 8'h5A;
    tick();
    idle();
    exp_q.push_back(8'h5A);
    rd_en = 1;
    tick();
    idle();
    chk("post_flush_empty", empty, 1);

    // DUT B: DEPTH=4, RDY_TH=4, asynchronous reset mid-burst
    for (int k = 1; k <= 4; k++) begin
      wr_en_b = 1; wr_data_b = 8'(8'hC0 + k);
      tick();
      chk("b_level", level_b, k);
      chk("b_wr_ready", wr_ready_b, (k < 4) ? 1 : 0);
    end
    chk("b_full", full_b, 1);
    chk("b_head", rd_data_b, 8'hC1);
    wr_data_b = 8'hC5;
    #3;
    rst_b = 1;
    #1;
    chk("b_rst_level", level_b, 0);
    chk("b_rst_empty", empty_b, 1);
    chk("b_rst_full", full_b, 0);
    chk("b_rst_wr_ready", wr_ready_b, 0);
    chk("b_rst_rd_data", rd_data_b, 0);
    chk("b_rst_ovf", ovf_b, 0);
    chk("b_rst_udf", udf_b, 0);
    wr_en_b = 0;
    tick();
    rst_b = 0;
    tick();
    chk("b_wr_ready_after_rst", wr_ready_b, 1);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
